// File: rtl/wave_counter.sv
// Modulo up/down counter that wraps in both directions over 0..max_val_p.
// Serves as the sample-address generator for wavetable oscillators.
module wave_counter #(
  parameter int  max_val_p = 99,
  localparam int width_lp  = (max_val_p < 1) ? 1 : $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                up_i,
  input  logic                down_i,
  output logic [width_lp-1:0] count_o
);

  generate
    if (max_val_p < 1) begin : g_bad_param
      $error("wave_counter: max_val_p must be >= 1");
    end
  endgenerate

  localparam logic [width_lp-1:0] max_lp  = width_lp'(max_val_p);
  localparam logic [width_lp-1:0] zero_lp = width_lp'(0);
  localparam logic [width_lp-1:0] one_lp  = width_lp'(1);

  logic [width_lp-1:0] count_q;
  logic [width_lp-1:0] count_d;

  // Next-state: explicit compare at both ends so the count never leaves 0..max_val_p.
  always_comb begin
    count_d = count_q;
    case ({up_i, down_i})
      2'b10: begin
        if (count_q == max_lp) begin
          count_d = zero_lp;
        end else begin
          count_d = count_q + one_lp;
        end
      end
      2'b01: begin
        if (count_q == zero_lp) begin
          count_d = max_lp;
        end else begin
          count_d = count_q - one_lp;
        end
      end
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous active-low clear taking priority.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      count_q <= zero_lp;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_wave_counter.sv
// Directed bench for wave_counter: a vector table on the default instance
// plus hand-written wrap/reset sequences across several max_val_p values.
module tb_wave_counter;

  logic       clk_i;
  logic       reset_i;
  logic       up_i;
  logic       down_i;
  logic [6:0] c99;
  logic [2:0] c5;
  logic [1:0] c2;
  logic [0:0] c1;
  logic [2:0] c7;

  int n_cmp = 0;
  int n_bad = 0;

  wave_counter #(.max_val_p(99)) dut99 (.clk_i(clk_i), .reset_i(reset_i), .up_i(up_i), .down_i(down_i), .count_o(c99));
  wave_counter #(.max_val_p(5))  dut5  (.clk_i(clk_i), .reset_i(reset_i), .up_i(up_i), .down_i(down_i), .count_o(c5));
  wave_counter #(.max_val_p(2))  dut2  (.clk_i(clk_i), .reset_i(reset_i), .up_i(up_i), .down_i(down_i), .count_o(c2));
  wave_counter #(.max_val_p(1))  dut1  (.clk_i(clk_i), .reset_i(reset_i), .up_i(up_i), .down_i(down_i), .count_o(c1));
  wave_counter #(.max_val_p(7))  dut7  (.clk_i(clk_i), .reset_i(reset_i), .up_i(up_i), .down_i(down_i), .count_o(c7));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic rst;
    logic up;
    logic dn;
    int   exp99;
  } vec_t;

  vec_t vecs[19];

  task automatic apply(input logic r, input logic u, input logic d);
    @(negedge clk_i);
    reset_i = r;
    up_i    = u;
    down_i  = d;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    reset_i = 1'b0;
    up_i    = 1'b0;
    down_i  = 1'b0;

    // reset held with up=1, release, count, hold (both encodings), then step down/up
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 2};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 3};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 4};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 5};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 6};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 7};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 7};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 7};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 7};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 7};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 7};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 7};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 7};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 7};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 6};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 7};

    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].rst, vecs[i].up, vecs[i].dn);
      check($sformatf("vec%0d", i), int'(c99), vecs[i].exp99);
    end

    // Up wrap across all instances from 0, 100 edges
    apply(1'b0, 1'b0, 1'b0);
    check("rst_all99", int'(c99), 0);
    check("rst_all1", int'(c1), 0);
    for (int i = 0; i < 100; i++) begin
      apply(1'b1, 1'b1, 1'b0);
      check($sformatf("up99_%0d", i), int'(c99), (i + 1) % 100);
      check($sformatf("up5_%0d", i),  int'(c5),  (i + 1) % 6);
      check($sformatf("up2_%0d", i),  int'(c2),  (i + 1) % 3);
      check($sformatf("up1_%0d", i),  int'(c1),  (i + 1) % 2);
      check($sformatf("up7_%0d", i),  int'(c7),  (i + 1) % 8);
    end

    // Down wrap from 0
    apply(1'b0, 1'b0, 1'b0);
    begin
      int e5[3] = '{5, 4, 3};
      int e2[3] = '{2, 1, 0};
      int e1[3] = '{1, 0, 1};
      int e7[3] = '{7, 6, 5};
      int e99[3] = '{99, 98, 97};
      for (int i = 0; i < 3; i++) begin
        apply(1'b1, 1'b0, 1'b1);
        check($sformatf("dn5_%0d", i),  int'(c5),  e5[i]);
        check($sformatf("dn2_%0d", i),  int'(c2),  e2[i]);
        check($sformatf("dn1_%0d", i),  int'(c1),  e1[i]);
        check($sformatf("dn7_%0d", i),  int'(c7),  e7[i]);
        check($sformatf("dn99_%0d", i), int'(c99), e99[i]);
      end
    end

    // Reset mid-count at 42
    apply(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 42; i++) begin
      apply(1'b1, 1'b1, 1'b0);
    end
    check("mid_pre", int'(c99), 42);
    apply(1'b0, 1'b1, 1'b0);
    check("mid_rst", int'(c99), 0);
    apply(1'b1, 1'b1, 1'b0);
    check("mid_resume", int'(c99), 1);
    apply(1'b1, 1'b1, 1'b0);
    check("mid_resume2", int'(c99), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
